// File: rtl/traffic_intersection_ctrl.sv
// Two-approach (NS/EW) intersection controller: timed phase sequence with all-red
// clearance, a latched pedestrian walk request and a flashing maintenance mode.
module traffic_intersection_ctrl #(
    parameter int TIMER_W  = 8,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       walk,
    output logic [3:0] phase_o
);

    typedef enum logic [3:0] {
        NS_G  = 4'd0,
        NS_Y  = 4'd1,
        AR1   = 4'd2,
        EW_G  = 4'd3,
        EW_Y  = 4'd4,
        AR2   = 4'd5,
        WALK1 = 4'd6,
        WALK2 = 4'd7,
        FLASH = 4'd8
    } phase_e;

    localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_T - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LD   = TIMER_W'(WALK_T - 1);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    phase_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 ped_pending_q, ped_pending_d;
    logic                 flash_phase_q, flash_phase_d;
    logic                 walk_entry;

    function automatic logic [TIMER_W-1:0] load_val(input phase_e p);
        case (p)
            NS_G, EW_G:   return GREEN_LD;
            NS_Y, EW_Y:   return YELLOW_LD;
            WALK1, WALK2: return WALK_LD;
            default:      return ALLRED_LD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= AR2;
            timer_q       <= ALLRED_LD;
            ped_pending_q <= 1'b0;
            flash_phase_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            flash_phase_q <= flash_phase_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        flash_phase_d = flash_phase_q;
        walk_entry    = 1'b0;
        if (tick) begin
            if (state_q == FLASH) begin
                flash_phase_d = ~flash_phase_q;
                if (!flash_mode) begin
                    state_d = AR2;
                    timer_d = ALLRED_LD;
                end
            end else if (timer_q != '0) begin
                timer_d = timer_q - 1'b1;
            end else begin
                case (state_q)
                    NS_G:    state_d = NS_Y;
                    NS_Y:    state_d = AR1;
                    EW_G:    state_d = EW_Y;
                    EW_Y:    state_d = AR2;
                    WALK1:   state_d = EW_G;
                    WALK2:   state_d = NS_G;
                    AR1:     state_d = flash_mode ? FLASH : (ped_pending_q ? WALK1 : EW_G);
                    AR2:     state_d = flash_mode ? FLASH : (ped_pending_q ? WALK2 : NS_G);
                    default: state_d = AR2;
                endcase
                timer_d       = load_val(state_d);
                // Only observed inside FLASH, so preloading it on every transition is harmless.
                flash_phase_d = 1'b1;
                walk_entry    = (state_d == WALK1) || (state_d == WALK2);
            end
        end
        // A request arriving on the walk-entry cycle wins over the clear.
        ped_pending_d = ped_req | (ped_pending_q & ~walk_entry);
    end

    always_comb begin
        ns_lights = LAMP_R;
        ew_lights = LAMP_R;
        walk      = 1'b0;
        case (state_q)
            NS_G:         ns_lights = LAMP_G;
            NS_Y:         ns_lights = LAMP_Y;
            EW_G:         ew_lights = LAMP_G;
            EW_Y:         ew_lights = LAMP_Y;
            WALK1, WALK2: walk = 1'b1;
            FLASH: begin
                ns_lights = flash_phase_q ? LAMP_Y : LAMP_OFF;
                ew_lights = flash_phase_q ? LAMP_R : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign phase_o = state_q;

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Two-approach (NS/EW) intersection controller with a timed phase sequence. Each phase length is set by a parameter. A tick strobe provides the time base. The block adds all-red clearance, a latched pedestrian walk request, and a flashing maintenance mode. It drives the lamp drivers and pedestrian signal heads directly; phase_o goes to status/debug logic.

Parameters:
TIMER_W, 8, width of the phase down-counter; every duration must be in 1..2^TIMER_W.
GREEN_T, 8, green duration in ticks (both approaches).
YELLOW_T, 3, yellow duration in ticks.
ALLRED_T, 2, all-red clearance duration in ticks.
WALK_T, 5, pedestrian walk duration in ticks.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
tick  in  1  time-base strobe; the timer advances only on cycles with tick=1
ped_req  in  1  pedestrian request pulse, sampled every clk
flash_mode  in  1  maintenance flash request (level)
ns_lights  out  3  NS lamps {R,Y,G}
ew_lights  out  3  EW lamps {R,Y,G}
walk  out  1  pedestrian walk lamp
phase_o  out  4  current phase encoding

Behaviour:
- Phases and phase_o encoding:
  - NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, WALK1=6, WALK2=7, FLASH=8.
- Outputs per phase (Moore decode of registered state; outputs change in the same cycle as the state register):
  - NS_G: ns=001, ew=100
  - NS_Y: ns=010, ew=100
  - EW_G: ns=100, ew=001
  - EW_Y: ns=100, ew=010
  - AR1/AR2/WALK1/WALK2: ns=100, ew=100
  - walk=1 only in WALK1/WALK2.
- Reset (async):
  - state=AR2, timer=ALLRED_T-1, ped_pending=0, flash_phase=1.
  - Outputs ns=100, ew=100, walk=0, phase_o=5.
- Timer:
  - On entry to a phase, timer loads that phase's duration minus 1.
  - On a clk edge with tick=1: if timer==0 the phase transitions, else timer decrements.
  - With tick=0, timer and state hold.
  - Net effect: each phase lasts exactly its duration in ticks.
- Normal sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G.
- Decision at expiry of AR1 or AR2 (priority order):
  1. flash_mode=1 → FLASH
  2. ped_pending=1 → WALK1 (from AR1) or WALK2 (from AR2)
  3. otherwise → the next green.
- WALK1 expiry → EW_G; WALK2 expiry → NS_G.
- flash_mode and ped_pending are checked only at all-red expiry. A green or yellow phase is never cut short.
- ped_pending:
  - Set on any clk with ped_req=1.
  - Cleared on the cycle entering WALK1/WALK2.
  - If set and clear coincide, set wins: pending remains 1 and a second walk is served at the next all-red.
  - Multiple requests before service collapse into one walk.
- FLASH:
  - flash_phase loads 1 on entry and toggles on each tick.
  - ns = flash_phase ? 010 : 000; ew = flash_phase ? 100 : 000; walk=0.
  - ped_pending keeps latching but is not served in FLASH.
  - On a tick with flash_mode=0, go to AR2 with timer=ALLRED_T-1, so the sequence restarts with clearance before NS_G.
- Never assert conflicting greens. In every non-FLASH phase at least one approach shows red.
- Reset mid-phase immediately forces the reset values; no partial phase survives.

Test Plan:
1. Reset, then tick=1 every cycle, no requests → AR2 2 cycles, NS_G 8, NS_Y 3, AR1 2, EW_G 8, EW_Y 3, AR2 2; period 26 cycles; ns/ew values match the table in every cycle.
2. tick asserted every 4th cycle → each phase lasts 4× its tick count (NS_G = 32 cycles); state holds on tick=0 cycles.
3. ped_req pulse during NS_G → after AR1 expires: WALK1 for 5 ticks with walk=1 and both approaches 100, then EW_G; ped_pending=0 afterwards. Three pulses during one green → exactly one walk.
4. ped_req asserted on the cycle WALK1 is entered → WALK2 also occurs after the next AR2.
5. flash_mode=1 raised during EW_G → EW_G and EW_Y complete, AR2 runs, then FLASH: ns alternates 010/000 and ew 100/000 per tick, starting 010/100. Drop flash_mode → AR2 for 2 ticks, then NS_G.
6. Reset asserted mid-EW_Y (async, between edges) → immediately ns=100, ew=100, walk=0, phase_o=5; after release the case-1 sequence repeats exactly.
